fwd_fifo: RTL
=============

// Module: fwd_fifo
// PURPOSE
//   Elastic buffer between Producer.outp_fwd and Consumer.inp_fwd.
//   Adds a valid/ready handshake to the forward path so a stalled consumer
//   back-pressures the producer instead of dropping values.
//   Registered storage of DEPTH entries; first-word-fall-through output.
// PARAMETERS
//   DATA_W   8   width of one forward word (fwd_pkg::FWD_W)
//   DEPTH    4   number of entries; any integer >= 2 (need not be a power of 2)
//   LEVEL_W  $clog2(DEPTH+1)   derived; width of level output, do not override
// PORTS
//   clk         in   1        single clock, all state on posedge
//   rst         in   1        asynchronous, active-low reset
//   inp_fwd     in   DATA_W   write data from upstream
//   inp_valid   in   1        upstream offers inp_fwd this cycle
//   inp_ready   out  1        fifo accepts this cycle (= level != DEPTH)
//   outp_fwd    out  DATA_W   head-of-queue data
//   outp_valid  out  1        outp_fwd holds a valid entry (= level != 0)
//   outp_ready  in   1        downstream consumes head this cycle
//   level       out  LEVEL_W  current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (rst low, async assert, sync-to-clk release handled upstream):
//     wr_ptr=0, rd_ptr=0, level=0 -> outp_valid=0, inp_ready=1.
//     Storage array is not reset; outp_fwd is don't-care while outp_valid=0.
//     Handshakes while rst low have no effect.
//   - push = inp_valid & inp_ready; pop = outp_valid & outp_ready.
//   - push: mem[wr_ptr] <= inp_fwd; wr_ptr advances.
//     pop: rd_ptr advances.
//     Both pointers wrap DEPTH-1 -> 0 explicitly (no power-of-2 masking).
//   - level: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
//   - Latency: word pushed at edge N is visible on outp_fwd with outp_valid=1
//     after edge N (1 cycle, empty case).
//     outp_fwd = mem[rd_ptr] combinationally from registers.
//   - No combinational in->out paths: inp_ready depends only on level,
//     never on outp_ready. Hence when full, a same-cycle pop does NOT allow a
//     push; the slot frees for the next cycle.
//   - Empty + inp_valid: push occurs; no bypass; pop impossible that cycle.
//   - Ordering strictly FIFO; no word dropped or duplicated under any
//     valid/ready pattern.
//   - Upstream must hold inp_fwd stable while inp_valid & ~inp_ready (assertion).
//   - Reset mid-operation: all contents discarded; the first push after
//     release lands in entry 0.
// STRUCTURE
//   - fwd_pkg: localparam FWD_W = 8; typedef logic [FWD_W-1:0] fwd_t.
//     Shared with Producer/Consumer.
//   - Single module, no sub-modules: pointer/level regs (always_ff, async
//     negedge rst) plus a register array with write enable.
//   - Helper function next_ptr(ptr) implements the wrap.
//   - Integration: top instantiates Producer -> fwd_fifo -> Consumer.
//     Producer gates its increment on inp_ready.
// TESTING
//   1 Reset: rst=0 mid-stream with level=3
//     -> level=0, outp_valid=0, inp_ready=1 asynchronously (before next clk).
//   2 Pass-through: outp_ready=1, push 8'h00..8'h0F on consecutive cycles
//     -> outp_fwd sequence 00..0F, each 1 cycle after push; level stays <=1.
//   3 Fill: outp_ready=0, DEPTH=4, push A1,A2,A3,A4,A5
//     -> level=4, inp_ready=0 after 4th push; A5 held.
//     Then release -> A1..A5 in order.
//   4 Full + simultaneous pop: level=4, inp_valid=1, outp_ready=1 for 1 cycle
//     -> no push that cycle, level=3; next cycle push accepted, level=4.
//   5 Wrap: DEPTH=3, random valid/ready (50%) for 1000 words
//     -> scoreboard exact order, level never >3 or <0, no loss.
//   6 Steady push&pop at level=2 for 10 cycles -> level constant 2,
//     data order preserved.

Source files
------------

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - forward-path word type shared by producer, fifo and consumer
package fwd_pkg;

  localparam int FWD_W = 8;

  typedef logic [FWD_W-1:0] fwd_t;

endpackage

// File: rtl/fwd_fifo.sv
// rtl/fwd_fifo.sv - first-word-fall-through elastic buffer on the forward path
module fwd_fifo
  import fwd_pkg::*;
#(
  parameter int DATA_W  = FWD_W,
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  inp_fwd,
  input  logic               inp_valid,
  output logic               inp_ready,
  output logic [DATA_W-1:0]  outp_fwd,
  output logic               outp_valid,
  input  logic               outp_ready,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               push, pop;

  logic               stall_q;
  logic [DATA_W-1:0]  held_q;

  // Ready and valid come only from the occupancy register, keeping in->out paths registered.
  always_comb begin
    inp_ready  = (level_q != LEVEL_W'(DEPTH));
    outp_valid = (level_q != '0);
    outp_fwd   = mem_q[rd_ptr_q];
    level      = level_q;
    push       = inp_valid & inp_ready;
    pop        = outp_valid & outp_ready;
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, written on push only and never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= inp_fwd;
    end
  end

  // Remember whether upstream was stalled last cycle and what it offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 1'b0;
      held_q  <= '0;
    end else begin
      stall_q <= inp_valid & ~inp_ready;
      held_q  <= inp_fwd;
    end
  end

  // A stalled offer must keep its data unchanged until it is accepted.
  always_ff @(posedge clk) begin
    if (rst && stall_q && inp_valid) begin
      hold_stable: assert (inp_fwd == held_q);
    end
  end

endmodule
